tech_rsff_pipe: RTL and testbench

TECH_RSFF_PIPE -- requirements
Module: tech_rsff_pipe

---
 rtl/tech_rsff_pipe_pkg.sv | 7 +
 rtl/tech_rsff_pipe_stage.sv | 33 +++
 rtl/tech_rsff_pipe.sv | 72 +++++++
 tb/tb_tech_rsff_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tech_rsff_pipe_pkg.sv
// tech_rsff_pkg: shared constants for the set/reset-forcing pipeline.
package tech_rsff_pkg;
  localparam int PRIO_SET = 0;
  localparam int PRIO_CLR = 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/tech_rsff_pipe_stage.sv
// tech_rsff_stage: one data+valid pipeline register; optional scan shift under TECH_RSFF_PIPE_SCAN_EN.
module tech_rsff_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
`ifdef TECH_RSFF_PIPE_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
`endif
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= INIT;
      q_valid <= 1'b0;
    end
`ifdef TECH_RSFF_PIPE_SCAN_EN
    else if (scan_en) q <= WIDTH'({q, scan_in});
`endif
    else if (flush) q_valid <= 1'b0;
    else if (en) begin
      q <= d;
      q_valid <= d_valid;
    end
  end
endmodule

// File: rtl/tech_rsff_pipe.sv
// tech_rsff_pipe: DEPTH-stage pipeline with per-bit set/clear forcing at capture; scan chain under TECH_RSFF_PIPE_SCAN_EN.
module tech_rsff_pipe
  import tech_rsff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int RESET_PRIO = 1,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] clr_v,
  input  logic [WIDTH-1:0] set_v,
  input  logic             flush,
`ifdef TECH_RSFF_PIPE_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] chain_d [DEPTH+1];
  logic chain_v [DEPTH+1];
  logic hit;
  always_comb res = RESET_PRIO == PRIO_CLR ? (d | set_v) & ~clr_v : (d & ~clr_v) | set_v;
  assign chain_d[0] = res;
  assign chain_v[0] = d_valid;
`ifdef TECH_RSFF_PIPE_SCAN_EN
  logic chain_s [DEPTH+1];
  assign chain_s[0] = scan_in;
  assign scan_out = chain_s[DEPTH];
  assign hit = en && d_valid && !flush && !scan_en && |(clr_v & set_v);
`else
  assign hit = en && d_valid && !flush && |(clr_v & set_v);
`endif
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    tech_rsff_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
      .clk(clk),
      .reset(reset),
      .en(en),
      .flush(flush),
      .d(chain_d[i]),
      .d_valid(chain_v[i]),
`ifdef TECH_RSFF_PIPE_SCAN_EN
      .scan_en(scan_en),
      .scan_in(chain_s[i]),
`endif
      .q(chain_d[i+1]),
      .q_valid(chain_v[i+1])
    );
`ifdef TECH_RSFF_PIPE_SCAN_EN
    assign chain_s[i+1] = chain_d[i+1][WIDTH-1];
`endif
  end
  assign q = chain_d[DEPTH];
  assign q_valid = chain_v[DEPTH];
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= DEPTH; k++) busy = busy | chain_v[k];
  end
  always_ff @(posedge clk) begin
    if (reset) conflict_cnt <= '0;
    else if (hit && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + 1'b1;
  end
endmodule

// File: tb/tb_tech_rsff_pipe.sv
// tb_tech_rsff_pipe: directed bench with a word-history model for both forcing priorities.
module tb_tech_rsff_pipe;
  localparam int W = 8;
  localparam int D = 2;
  localparam logic [W-1:0] INIT = 8'hA5;
  logic clk = 1'b0;
  logic reset, en, d_valid, flush;
  logic [W-1:0] d, clr_v, set_v;
  logic [W-1:0] q1, q0;
  logic qv1, qv0, busy1, busy0;
  logic [7:0] cnt1, cnt0;
  int checks = 0;
  int failures = 0;
  bit mon = 1'b0;
  always #5 clk = ~clk;

`ifdef TECH_RSFF_PIPE_SCAN_EN
  logic so1, so0;
  logic sr, sen, sdv, sfl, sse, ssi, sqv, sbusy, sso;
  logic [3:0] sd, sclr, sset, sq;
  logic [7:0] scnt;
  logic [7:0] pat = 8'b01001101;
  tech_rsff_pipe #(.WIDTH(4), .DEPTH(2), .RESET_PRIO(1), .INIT(4'h0)) u_scan (
    .clk(clk), .reset(sr), .en(sen), .d(sd), .d_valid(sdv), .clr_v(sclr), .set_v(sset),
    .flush(sfl), .scan_en(sse), .scan_in(ssi), .scan_out(sso),
    .q(sq), .q_valid(sqv), .busy(sbusy), .conflict_cnt(scnt));
`endif

  tech_rsff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_PRIO(1), .INIT(INIT)) u_clr (
    .clk(clk), .reset(reset), .en(en), .d(d), .d_valid(d_valid), .clr_v(clr_v), .set_v(set_v),
    .flush(flush),
`ifdef TECH_RSFF_PIPE_SCAN_EN
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(so1),
`endif
    .q(q1), .q_valid(qv1), .busy(busy1), .conflict_cnt(cnt1));

  tech_rsff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_PRIO(0), .INIT(INIT)) u_set (
    .clk(clk), .reset(reset), .en(en), .d(d), .d_valid(d_valid), .clr_v(clr_v), .set_v(set_v),
    .flush(flush),
`ifdef TECH_RSFF_PIPE_SCAN_EN
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(so0),
`endif
    .q(q0), .q_valid(qv0), .busy(busy0), .conflict_cnt(cnt0));

  // Model keeps the raw captured words; forcing is resolved only when a word reaches q.
  typedef struct {logic [W-1:0] d, c, s; logic v;} word_t;
  word_t hist [D];
  int mcnt;

  function automatic logic [W-1:0] resolve(word_t w, bit clr_wins);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++)
      r[b] = (w.c[b] && w.s[b]) ? !clr_wins : w.c[b] ? 1'b0 : w.s[b] ? 1'b1 : w.d[b];
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < D; k++) hist[k] <= '{INIT, '0, '0, 1'b0};
      mcnt <= 0;
    end else if (flush) begin
      for (int k = 0; k < D; k++) hist[k].v <= 1'b0;
    end else if (en) begin
      hist[0] <= '{d, clr_v, set_v, d_valid};
      for (int k = 1; k < D; k++) hist[k] <= hist[k-1];
      if (d_valid && (clr_v & set_v) != '0 && mcnt < 255) mcnt <= mcnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      logic be;
      be = 1'b0;
      for (int k = 0; k < D; k++) be = be | hist[k].v;
      chk("m_q_clr", q1, resolve(hist[D-1], 1'b1));
      chk("m_q_set", q0, resolve(hist[D-1], 1'b0));
      chk("m_qv_clr", qv1, hist[D-1].v);
      chk("m_qv_set", qv0, hist[D-1].v);
      chk("m_busy_clr", busy1, be);
      chk("m_busy_set", busy0, be);
      chk("m_cnt_clr", cnt1, mcnt);
      chk("m_cnt_set", cnt0, mcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {logic en, dv, fl; logic [7:0] d, c, s;} vec_t;
  vec_t tbl [10] = '{
    '{1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00},
    '{1'b1, 1'b1, 1'b0, 8'h34, 8'hF0, 8'h0F},
    '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h0F},
    '{1'b0, 1'b1, 1'b0, 8'h56, 8'hFF, 8'hFF},
    '{1'b1, 1'b1, 1'b1, 8'h78, 8'h11, 8'h11},
    '{1'b1, 1'b1, 1'b0, 8'h9A, 8'hC3, 8'h3C},
    '{1'b1, 1'b1, 1'b0, 8'hBC, 8'hAA, 8'hAA},
    '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00},
    '{1'b1, 1'b1, 1'b0, 8'hDE, 8'h00, 8'hFF},
    '{1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h00}};

  initial begin
    reset = 1'b1; en = 1'b0; d_valid = 1'b0; flush = 1'b0;
    d = '0; clr_v = '0; set_v = '0;
`ifdef TECH_RSFF_PIPE_SCAN_EN
    sr = 1'b1; sen = 1'b0; sdv = 1'b0; sfl = 1'b0; sse = 1'b0; ssi = 1'b0;
    sd = '0; sclr = '0; sset = '0;
`endif
    tick();
    mon = 1'b1;
    chk("rst_q", q1, 8'hA5);
    chk("rst_qv", qv1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_cnt", cnt1, 8'd0);
    reset = 1'b0; en = 1'b1; d = 8'h3C; d_valid = 1'b1;
    tick();
    chk("lat_early_qv", qv1, 1'b0);
    d_valid = 1'b0; d = 8'h00;
    tick();
    chk("lat_q", q1, 8'h3C);
    chk("lat_qv", qv1, 1'b1);
    tick();
    chk("lat_qv_once", qv1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0; d = 8'h00; set_v = 8'h0F; clr_v = 8'h03; d_valid = 1'b1;
    tick();
    set_v = '0; clr_v = '0; d_valid = 1'b0;
    tick();
    chk("prio_clr_q", q1, 8'h0C);
    chk("prio_set_q", q0, 8'h0F);
    chk("prio_clr_cnt", cnt1, 8'd1);
    chk("prio_set_cnt", cnt0, 8'd1);
    d = 8'hFF; clr_v = 8'h81; set_v = 8'h81;
    tick();
    clr_v = '0; set_v = '0;
    tick();
    chk("nv_force_q", q1, 8'h7E);
    chk("nv_force_qv", qv1, 1'b0);
    chk("nv_force_cnt", cnt1, 8'd1);
    d_valid = 1'b1;
    d = 8'h11; tick();
    d = 8'h22; tick();
    d = 8'h33; tick();
    chk("stream_q", q1, 8'h22);
    chk("stream_busy", busy1, 1'b1);
    en = 1'b0; d = 8'h44;
    tick(); tick();
    chk("stall_q", q1, 8'h22);
    chk("stall_qv", qv1, 1'b1);
    flush = 1'b1; en = 1'b1;
    tick();
    flush = 1'b0; en = 1'b0; d_valid = 1'b0;
    chk("flush_qv", qv1, 1'b0);
    chk("flush_busy", busy1, 1'b0);
    chk("flush_q_hold", q1, 8'h22);
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; d_valid = tbl[i].dv; flush = tbl[i].fl;
      d = tbl[i].d; clr_v = tbl[i].c; set_v = tbl[i].s;
      tick();
    end
    en = 1'b1; d_valid = 1'b1; flush = 1'b0; d = 8'h5A; clr_v = '0; set_v = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_q", q1, 8'hA5);
    chk("midrst_qv", qv1, 1'b0);
    chk("midrst_busy", busy1, 1'b0);
    reset = 1'b0; clr_v = 8'h01; set_v = 8'h01;
    repeat (254) tick();
    chk("sat_254", cnt1, 8'd254);
    tick();
    chk("sat_255", cnt1, 8'd255);
    repeat (45) tick();
    chk("sat_hold", cnt1, 8'd255);
    chk("sat_hold_set", cnt0, 8'd255);
    en = 1'b0; d_valid = 1'b0; clr_v = '0; set_v = '0;
`ifdef TECH_RSFF_PIPE_SCAN_EN
    tick();
    sr = 1'b0; sen = 1'b1; sdv = 1'b1; sd = 4'h9;
    tick();
    sdv = 1'b0; sse = 1'b1; sfl = 1'b1; sclr = 4'hF; sset = 4'hF; sdv = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ssi = (i < 8) ? pat[i] : 1'b0;
      tick();
      if (i >= 7) chk("scan_out", sso, pat[i-7]);
    end
    chk("scan_qv", sqv, 1'b0);
    chk("scan_busy", sbusy, 1'b1);
    chk("scan_cnt", scnt, 8'd0);
    sse = 1'b0; sen = 1'b0; sfl = 1'b0;
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
